// File: rtl/dma_bus_arbiter.sv
// Bus arbiter between the 8088 CPU and the 8237A DMA controller: turns hrq into a guarded hlda.
// Optional DMA page registers (A19..A16) are built when DMA_PAGE_REG_EN is defined.
module dma_bus_arbiter #(
  parameter int GUARD_CYCLES   = 2,
  parameter int MIN_CPU_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hrq,
  output logic       hlda,
  input  logic [2:0] cpu_s_n,
  input  logic       cpu_lock_n,
  output logic       cpu_hold,
  output logic       dma_aen,
  input  logic [3:0] dack,
  input  logic       page_cs,
  input  logic       io_wr,
  input  logic [1:0] io_addr,
  input  logic [3:0] io_data,
  output logic [3:0] page_addr
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int CW = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_HOLD  = 3'd2,
    S_GRANT = 3'd3,
    S_REL   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [CW-1:0]   cool_q, cool_d;
  logic            hlda_q, hlda_d;
  logic            aen_q, aen_d;
  logic            hold_q, hold_d;
  logic            bus_idle;

  assign bus_idle = (cpu_s_n == 3'b111) && cpu_lock_n;

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    cool_d  = cool_q;
    unique case (state_q)
      S_IDLE: begin
        if (cool_q != '0) begin
          cool_d = cool_q - CW'(1);
        end else if (hrq) begin
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (!hrq) begin
          state_d = S_IDLE;
        end else if (bus_idle) begin
          state_d = S_HOLD;
          guard_d = GW'(GUARD_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (!hrq) begin
          state_d = S_REL;
        end else if (guard_q == '0) begin
          state_d = S_GRANT;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      S_GRANT: begin
        if (!hrq) state_d = S_REL;
      end
      S_REL: begin
        state_d = S_IDLE;
        cool_d  = CW'(MIN_CPU_CYCLES);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    hlda_d = (state_d == S_GRANT);
    aen_d  = (state_d == S_HOLD) || (state_d == S_GRANT);
    hold_d = (state_d == S_HOLD) || (state_d == S_GRANT) || (state_d == S_REL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      guard_q <= '0;
      cool_q  <= '0;
      hlda_q  <= 1'b0;
      aen_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      cool_q  <= cool_d;
      hlda_q  <= hlda_d;
      aen_q   <= aen_d;
      hold_q  <= hold_d;
    end
  end

  assign hlda     = hlda_q;
  assign dma_aen  = aen_q;
  assign cpu_hold = hold_q;

`ifdef DMA_PAGE_REG_EN
  logic [3:0] page_q [4];
  logic [3:0] page_d [4];
  logic [3:0] page_addr_q, page_addr_d;

  // A write landing on the active channel is forwarded so page_addr tracks it on the same edge.
  always_comb begin
    for (int i = 0; i < 4; i++) page_d[i] = page_q[i];
    if (page_cs && io_wr) page_d[io_addr] = io_data;
    page_addr_d = 4'b0;
    if (state_d == S_GRANT) begin
      if      (dack[0]) page_addr_d = page_d[0];
      else if (dack[1]) page_addr_d = page_d[1];
      else if (dack[2]) page_addr_d = page_d[2];
      else if (dack[3]) page_addr_d = page_d[3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) page_q[i] <= 4'b0;
      page_addr_q <= 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) page_q[i] <= page_d[i];
      page_addr_q <= page_addr_d;
    end
  end

  assign page_addr = page_addr_q;
`else
  logic unused_page_inputs;
  assign unused_page_inputs = ^{page_cs, io_wr, io_addr, io_data, dack};
  assign page_addr = 4'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: table-driven sequences, directed corner cases and a random run
// compared against an ownership-level model of the bus hand-over.
module tb_dma_bus_arbiter;
  localparam int G = 2;
  localparam int M = 4;

  logic       clk, reset, hrq, hlda, cpu_lock_n, cpu_hold, dma_aen, page_cs, io_wr;
  logic [2:0] cpu_s_n;
  logic [3:0] dack, io_data, page_addr;
  logic [1:0] io_addr;

  int checks   = 0;
  int failures = 0;

  dma_bus_arbiter #(.GUARD_CYCLES(G), .MIN_CPU_CYCLES(M)) dut (
    .clk(clk), .reset(reset), .hrq(hrq), .hlda(hlda), .cpu_s_n(cpu_s_n),
    .cpu_lock_n(cpu_lock_n), .cpu_hold(cpu_hold), .dma_aen(dma_aen), .dack(dack),
    .page_cs(page_cs), .io_wr(io_wr), .io_addr(io_addr), .io_data(io_data),
    .page_addr(page_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the bus and how long each waiting period still has to run.
  bit         m_wants, m_turnaround, m_dma_owns, m_handback;
  int         m_guard_left, m_cool_left;
  logic [3:0] m_page [4];

  task automatic model_step();
    if (reset) begin
      m_wants = 0; m_turnaround = 0; m_dma_owns = 0; m_handback = 0;
      m_guard_left = 0; m_cool_left = 0;
      for (int i = 0; i < 4; i++) m_page[i] = 4'h0;
    end else begin
      if (page_cs && io_wr) m_page[io_addr] = io_data;
      if (m_handback) begin
        m_handback = 0;
        m_cool_left = M;
      end else if (m_dma_owns) begin
        if (!hrq) begin m_dma_owns = 0; m_handback = 1; end
      end else if (m_turnaround) begin
        if (!hrq) begin m_turnaround = 0; m_handback = 1; end
        else if (m_guard_left == 0) begin m_turnaround = 0; m_dma_owns = 1; end
        else m_guard_left = m_guard_left - 1;
      end else if (m_wants) begin
        if (!hrq) m_wants = 0;
        else if (cpu_s_n == 3'b111 && cpu_lock_n) begin
          m_wants = 0; m_turnaround = 1; m_guard_left = G - 1;
        end
      end else begin
        if (m_cool_left > 0) m_cool_left = m_cool_left - 1;
        else if (hrq) m_wants = 1;
      end
    end
  endtask

  function automatic logic [3:0] exp_page();
`ifdef DMA_PAGE_REG_EN
    if (!m_dma_owns) return 4'h0;
    for (int i = 0; i < 4; i++) if (dack[i]) return m_page[i];
    return 4'h0;
`else
    return 4'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("m_hlda", {7'd0, hlda}, {7'd0, m_dma_owns});
    chk("m_aen", {7'd0, dma_aen}, {7'd0, m_dma_owns | m_turnaround});
    chk("m_hold", {7'd0, cpu_hold}, {7'd0, m_dma_owns | m_turnaround | m_handback});
    chk("m_page", {4'd0, page_addr}, {4'd0, exp_page()});
    chk("inv_hlda", {7'd0, hlda & ~(dma_aen & cpu_hold)}, 8'd0);
  endtask

  task automatic count_to_hlda(input string name, input int want);
    int n = 0;
    while (hlda !== 1'b1 && n < 20) begin tick(); n++; end
    chk(name, n[7:0], want[7:0]);
  endtask

  typedef struct {
    bit hrq; bit [2:0] s_n; bit lock_n;
    bit e_hlda; bit e_aen; bit e_hold;
  } vec_t;
  vec_t tbl [15];

  initial begin
    logic [3:0] e_pg;
    tbl[0]  = '{1, 3'b111, 1, 0, 0, 0};
    tbl[1]  = '{1, 3'b111, 1, 0, 1, 1};
    tbl[2]  = '{1, 3'b111, 1, 0, 1, 1};
    tbl[3]  = '{1, 3'b111, 1, 1, 1, 1};
    tbl[4]  = '{1, 3'b111, 1, 1, 1, 1};
    tbl[5]  = '{0, 3'b111, 1, 0, 0, 1};
    tbl[6]  = '{0, 3'b111, 1, 0, 0, 0};
    tbl[7]  = '{1, 3'b111, 1, 0, 0, 0};
    tbl[8]  = '{1, 3'b111, 1, 0, 0, 0};
    tbl[9]  = '{1, 3'b111, 1, 0, 0, 0};
    tbl[10] = '{1, 3'b111, 1, 0, 0, 0};
    tbl[11] = '{1, 3'b111, 1, 0, 0, 0};
    tbl[12] = '{1, 3'b111, 1, 0, 1, 1};
    tbl[13] = '{0, 3'b111, 1, 0, 0, 1};
    tbl[14] = '{0, 3'b111, 1, 0, 0, 0};

    reset = 1; hrq = 0; cpu_s_n = 3'b111; cpu_lock_n = 1; dack = 0;
    page_cs = 0; io_wr = 0; io_addr = 0; io_data = 0;
    tick(); tick();
    reset = 0;
    chk("rst_hlda", {7'd0, hlda}, 8'd0);
    chk("rst_aen", {7'd0, dma_aen}, 8'd0);
    chk("rst_hold", {7'd0, cpu_hold}, 8'd0);
    chk("rst_page", {4'd0, page_addr}, 8'd0);

    // Grant, release, cooldown with hrq held, then an aborted turnaround.
    for (int i = 0; i < 15; i++) begin
      hrq = tbl[i].hrq; cpu_s_n = tbl[i].s_n; cpu_lock_n = tbl[i].lock_n;
      tick();
      chk($sformatf("tbl%0d_hlda", i), {7'd0, hlda}, {7'd0, tbl[i].e_hlda});
      chk($sformatf("tbl%0d_aen", i), {7'd0, dma_aen}, {7'd0, tbl[i].e_aen});
      chk($sformatf("tbl%0d_hold", i), {7'd0, cpu_hold}, {7'd0, tbl[i].e_hold});
    end
    repeat (6) tick();

    // Non-passive status stalls the request.
    hrq = 1; cpu_s_n = 3'b100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_busy_hlda", {7'd0, hlda}, 8'd0);
    end
    cpu_s_n = 3'b111;
    count_to_hlda("t2_latency", G + 1);
    hrq = 0; repeat (8) tick();

    // Locked bus stalls the request; unlocking starts the normal sequence.
    cpu_lock_n = 0; hrq = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_lock_aen", {7'd0, dma_aen}, 8'd0);
    end
    cpu_lock_n = 1;
    count_to_hlda("t3_latency", G + 1);

    // Page registers written while granted.
    page_cs = 1; io_wr = 1; io_addr = 2; io_data = 4'hA; dack = 4'b0100;
    tick();
`ifdef DMA_PAGE_REG_EN
    e_pg = 4'hA;
`else
    e_pg = 4'h0;
`endif
    chk("t5_page_ch2", {4'd0, page_addr}, {4'd0, e_pg});
    io_addr = 0; io_data = 4'h3; dack = 4'b0101;
    tick();
`ifdef DMA_PAGE_REG_EN
    e_pg = 4'h3;
`else
    e_pg = 4'h0;
`endif
    chk("t5_page_ch0", {4'd0, page_addr}, {4'd0, e_pg});
    page_cs = 0; io_wr = 0;

    // Reset while granted, then an immediate re-grant without cooldown.
    reset = 1;
    tick();
    chk("t6_hlda", {7'd0, hlda}, 8'd0);
    chk("t6_aen", {7'd0, dma_aen}, 8'd0);
    chk("t6_hold", {7'd0, cpu_hold}, 8'd0);
    reset = 0; dack = 4'b0100;
    count_to_hlda("t6_regrant", 2 + G);
    chk("t6_page_cleared", {4'd0, page_addr}, 8'd0);
    hrq = 0; tick();
    chk("t5_page_release", {4'd0, page_addr}, 8'd0);
    repeat (6) tick();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) hrq = ~hrq;
      cpu_s_n    = ($urandom_range(9) < 6) ? 3'b111 : 3'($urandom);
      cpu_lock_n = ($urandom_range(5) != 0);
      dack       = 4'($urandom);
      page_cs    = ($urandom_range(3) == 0);
      io_wr      = ($urandom_range(1) == 0);
      io_addr    = 2'($urandom);
      io_data    = 4'($urandom);
      reset      = ($urandom_range(199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
